uart_rx_fifo: RTL and testbench

- UART 8N1 receiver with an integrated receive FIFO. It turns the asynchronous serial line into buffered bytes for the SoC's memory-mapped UART peripheral.
- It is the receive half of the SoC UART. It pairs with the existing transmit path and is sized by the same CLOCK_FREQ, BAUD_RATE and UART_BUFFER_SIZE values the SoC top takes.
- Bus-side reads use a first-word-fall-through handshake.

---
 rtl/uart_rx_fifo.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a first-word-fall-through receive FIFO.
// The serial line is synchronised, framed by a small FSM sampling mid-bit,
// and complete bytes are pushed into a circular buffer read by the bus side.
//
// Read handshake: rd_data is valid whenever empty=0 (the head byte is shown
// combinationally). Asserting rd_en while empty=0 consumes that byte on the
// next rising edge; rd_en while empty=1 is ignored.
module uart_rx_fifo #(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int BAUD_RATE   = 115200,
  parameter int BUFFER_SIZE = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx,
  input  logic                         rd_en,
  input  logic                         clear_errors,
  output logic [7:0]                   rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(BUFFER_SIZE):0] count,
  output logic                         frame_error,
  output logic                         overrun,
  output logic [2:0]                   fsm_state
);

  localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int AW           = $clog2(BUFFER_SIZE);
  localparam int CW           = AW + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CW-1:0]    DEPTH     = CW'(BUFFER_SIZE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       idx, idx_nx;
  logic [7:0]       shift, shift_nx;
  logic             rx_meta, rx_s;
  logic             wr_req, fe_set, ovr_set;
  logic             do_wr, do_rd;

  logic [7:0]       mem [BUFFER_SIZE];
  logic [AW-1:0]    wr_ptr, rd_ptr;

  // Two-flop synchroniser; idle-high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // Receiver state register plus bit timer, bit index and shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      shift <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      idx   <= idx_nx;
      shift <= shift_nx;
    end
  end

  // Receiver next-state: mid-bit sampling, stop-bit check, break absorption.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shift_nx = shift;
    wr_req   = 1'b0;
    fe_set   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!rx_s) begin
          cnt_nx   = '0;
          state_nx = S_START;
        end
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = rx_s ? S_IDLE : S_DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_nx   = '0;
          shift_nx = {rx_s, shift[7:1]};
          if (idx == 3'd7) state_nx = S_STOP;
          else             idx_nx   = idx + 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_nx = '0;
          if (rx_s) begin
            wr_req   = 1'b1;
            state_nx = S_IDLE;
          end else begin
            fe_set   = 1'b1;
            state_nx = S_BREAK;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign fsm_state = state;

  // A full FIFO can still accept a byte if a read frees a slot this cycle.
  assign do_rd   = rd_en & ~empty;
  assign do_wr   = wr_req & (~full | do_rd);
  assign ovr_set = wr_req & full & ~do_rd;

  // Byte storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= shift;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == DEPTH);
  assign rd_data = empty ? 8'h00 : mem[rd_ptr];

  // Sticky error flags; a new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (fe_set)            frame_error <= 1'b1;
      else if (clear_errors) frame_error <= 1'b0;
      if (ovr_set)           overrun <= 1'b1;
      else if (clear_errors) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at CLKS_PER_BIT=10 with a 4-byte FIFO.
module tb_uart_rx_fifo;

  localparam int BS = 4;
  localparam int CW = $clog2(BS) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx;
  logic          rd_en;
  logic          clear_errors;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic          frame_error;
  logic          overrun;
  logic [2:0]    fsm_state;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int lat;

  uart_rx_fifo #(
    .CLOCK_FREQ (1000000),
    .BAUD_RATE  (100000),
    .BUFFER_SIZE(BS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx          (rx),
    .rd_en       (rd_en),
    .clear_errors(clear_errors),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .frame_error (frame_error),
    .overrun     (overrun),
    .fsm_state   (fsm_state)
  );

  // Clock and reset block
  always #5 clk = ~clk;

  // Monitor: every accepted pop is compared with the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && rd_en && !empty) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h, required no byte", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %h, required %h", rd_data, e);
        end
      end
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) step();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    repeat (10) step();
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (10) step();
    end
    rx = stop_bit;
    repeat (10) step();
    rx = 1'b1;
  endtask

  task automatic read_one();
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_empty"}, 32'(empty), 1);
    check({tag, "_full"}, 32'(full), 0);
    check({tag, "_count"}, 32'(count), 0);
    check({tag, "_rd_data"}, 32'(rd_data), 0);
    check({tag, "_frame_error"}, 32'(frame_error), 0);
    check({tag, "_overrun"}, 32'(overrun), 0);
    check({tag, "_state"}, 32'(fsm_state), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    rd_en = 1'b0;
    clear_errors = 1'b0;
    repeat (3) step();
    check_reset_values("reset");
    rst_n = 1'b1;
    idle(3);

    // Single byte with latency measurement from the start edge
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        while (empty && lat < 200) begin
          step();
          lat++;
        end
      end
    join
    check("a5_latency_window", 32'(lat >= 96 && lat <= 99), 1);
    check("a5_count", 32'(count), 1);
    check("a5_head", 32'(rd_data), 32'hA5);
    read_one();
    check("a5_empty_after_read", 32'(empty), 1);
    check("a5_count_after_read", 32'(count), 0);
    check("a5_no_frame_error", 32'(frame_error), 0);
    check("a5_no_overrun", 32'(overrun), 0);

    // Glitch rejection, then a normal byte
    rx = 1'b0;
    repeat (3) step();
    idle(20);
    check("glitch_state_idle", 32'(fsm_state), 0);
    check("glitch_count", 32'(count), 0);
    check("glitch_frame_error", 32'(frame_error), 0);
    exp_q.push_back(8'h3C);
    send_byte(8'h3C, 1'b1);
    idle(3);
    check("after_glitch_count", 32'(count), 1);
    read_one();

    // Framing error followed by a long break, then a good byte
    send_byte(8'h3C, 1'b0);
    rx = 1'b0;
    repeat (50) step();
    idle(3);
    check("break_frame_error", 32'(frame_error), 1);
    check("break_no_byte", 32'(count), 0);
    exp_q.push_back(8'h55);
    send_byte(8'h55, 1'b1);
    idle(3);
    check("break_one_byte", 32'(count), 1);
    check("break_flag_sticky", 32'(frame_error), 1);
    read_one();
    clear_errors = 1'b1;
    step();
    clear_errors = 1'b0;
    check("frame_error_cleared", 32'(frame_error), 0);

    // Overrun: five bytes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1);
      idle(3);
    end
    check("ovr_full", 32'(full), 1);
    check("ovr_count", 32'(count), 4);
    check("ovr_flag", 32'(overrun), 1);
    repeat (4) read_one();
    check("ovr_empty_after_reads", 32'(empty), 1);
    read_one();
    check("ovr_read_when_empty_count", 32'(count), 0);
    clear_errors = 1'b1;
    step();
    clear_errors = 1'b0;
    check("overrun_cleared", 32'(overrun), 0);

    // Full FIFO with a read landing on the stop-sample edge
    for (int i = 1; i <= 4; i++) begin
      exp_q.push_back(8'(i));
      send_byte(8'(i), 1'b1);
      idle(3);
    end
    check("full_before_99", 32'(full), 1);
    exp_q.push_back(8'h99);
    fork
      send_byte(8'h99, 1'b1);
      begin
        repeat (97) step();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
      end
    join
    idle(3);
    check("simul_rw_no_overrun", 32'(overrun), 0);
    check("simul_rw_count", 32'(count), 4);
    repeat (4) read_one();
    check("simul_rw_empty", 32'(empty), 1);

    // Reset in the middle of a frame with bytes queued
    send_byte(8'h11, 1'b1);
    idle(3);
    send_byte(8'h22, 1'b1);
    idle(3);
    check("pre_reset_count", 32'(count), 2);
    fork
      send_byte(8'hF0, 1'b1);
      begin
        repeat (45) step();
        rst_n = 1'b0;
        #1;
        check_reset_values("midframe_reset");
      end
    join
    rst_n = 1'b1;
    idle(3);
    exp_q.push_back(8'hC3);
    send_byte(8'hC3, 1'b1);
    idle(3);
    check("post_reset_count", 32'(count), 1);
    check("post_reset_head", 32'(rd_data), 32'hC3);
    read_one();

    check("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
